// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, status/cause field positions.
// Build option: CP0_PRID_EN adds the read-only PRId register at address 15.
package cp0_pkg;

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam int IM_LSB      = 10;
  localparam int IM_MSB      = 15;
  localparam int IP_LSB      = 10;
  localparam int IP_MSB      = 15;
  localparam int EXL_BIT     = 1;
  localparam int IE_BIT      = 0;
  localparam int BD_BIT      = 31;
  localparam int EXCCODE_LSB = 2;
  localparam int EXCCODE_MSB = 6;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] PRID_VALUE = 32'h4255_4141;

  function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                          input logic ie);
    logic [31:0] r;
    r = '0;
    r[IM_MSB:IM_LSB] = im;
    r[EXL_BIT]       = exl;
    r[IE_BIT]        = ie;
    return r;
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] code);
    logic [31:0] r;
    r = '0;
    r[BD_BIT]                  = bd;
    r[IP_MSB:IP_LSB]           = ip;
    r[EXCCODE_MSB:EXCCODE_LSB] = code;
    return r;
  endfunction

endpackage

// File: rtl/cp0_req.sv
// Combinational interrupt/exception request logic; interrupts take priority over exceptions.
module cp0_req
  import cp0_pkg::*;
(
  input  logic       ie_i,
  input  logic       exl_i,
  input  logic [5:0] im_i,
  input  logic [5:0] hw_int_i,
  input  logic [4:0] exc_code_i,
  output logic       int_req_o,
  output logic       exc_req_o,
  output logic       req_o
);

  assign int_req_o = ie_i & ~exl_i & (|(hw_int_i & im_i));
  assign exc_req_o = ~exl_i & (exc_code_i != EXC_INT);
  assign req_o     = int_req_o | exc_req_o;

endmodule

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC registers, exception entry and mtc0/mfc0 access.
// Build option: CP0_PRID_EN makes address 15 read the PRId constant; otherwise it reads 0.
module cp0
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic        req,
  output logic [31:0] epc_out
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req, exc_req;
  logic        wr_sr, wr_epc;
  logic [31:0] epc_raw, exc_epc;

  cp0_req u_req (
    .ie_i       (ie_q),
    .exl_i      (exl_q),
    .im_i       (im_q),
    .hw_int_i   (hw_int),
    .exc_code_i (exc_code_in),
    .int_req_o  (int_req),
    .exc_req_o  (exc_req),
    .req_o      (req)
  );

  assign wr_sr   = en & ~req & (cp0_addr == ADDR_SR);
  assign wr_epc  = en & ~req & (cp0_addr == ADDR_EPC);
  // A delay-slot instruction restarts at its branch, one word earlier.
  assign epc_raw = bd_in ? (vpc - 32'd4) : vpc;
  assign exc_epc = epc_raw & ~32'd3;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = hw_int;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (req) begin
      exl_d      = 1'b1;
      exc_code_d = int_req ? EXC_INT : exc_code_in;
      bd_d       = bd_in;
      epc_d      = exc_epc;
    end else begin
      if (wr_sr) begin
        im_d  = cp0_wdata[IM_MSB:IM_LSB];
        exl_d = cp0_wdata[EXL_BIT];
        ie_d  = cp0_wdata[IE_BIT];
      end
      if (wr_epc) begin
        epc_d = cp0_wdata & ~32'd3;
      end
      // eret wins over a concurrent SR write for the EXL bit only.
      if (exl_clr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = pack_sr(im_q, exl_q, ie_q);
      ADDR_CAUSE: cp0_rdata = pack_cause(bd_q, ip_q, exc_code_q);
      ADDR_EPC:   cp0_rdata = epc_q;
`ifdef CP0_PRID_EN
      ADDR_PRID:  cp0_rdata = PRID_VALUE;
`endif
      default:    cp0_rdata = '0;
    endcase
  end

  assign epc_out = wr_epc ? cp0_wdata : epc_q;

endmodule
